// File: rtl/img_pkg.sv
// Shared constants and the line-feed scheduler state type for the 4-line-buffer
// 3x3 window path.
package img_pkg;
  localparam int LB_LINE_WIDTH = 512;
  localparam int LB_NUM        = 4;
  localparam int CRED_W        = 3;

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    WAIT_CREDIT,
    DRAIN,
    DONE
  } line_feed_state_t;
endpackage

// File: rtl/lb_credit_counter.sv
// Saturating up/down line-buffer credit counter. Simultaneous inc/dec cancel.
// The overflow flag exists only when LINE_FEED_ERR_CHECK_EN is defined.
module lb_credit_counter import img_pkg::*; #(
  parameter int W   = CRED_W,
  parameter int MAX = LB_NUM
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_nxt_o
`ifdef LINE_FEED_ERR_CHECK_EN
  ,
  output logic         ovf_o
`endif
);
  localparam logic [W-1:0] MAXV = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = MAXV;
    else if (inc_i && !dec_i && (cnt_q != MAXV))
      cnt_d = cnt_q + 1'b1;
    else if (dec_i && !inc_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= MAXV;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;

`ifdef LINE_FEED_ERR_CHECK_EN
  // A return that would push past the pool size means the controller and we disagree.
  assign ovf_o = inc_i && !dec_i && (cnt_q == MAXV);
`endif
endmodule

// File: rtl/line_feed_scheduler.sv
// Valid/ready front end for the window controller: feeds a line only when a line
// buffer credit is free. Optional sticky protocol error: LINE_FEED_ERR_CHECK_EN.
module line_feed_scheduler import img_pkg::*; #(
  parameter int LINE_WIDTH  = LB_LINE_WIDTH,
  parameter int FRAME_LINES = 512,
  parameter int NUM_LB      = LB_NUM
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] s_pixel_data,
  input  logic       s_pixel_valid,
  output logic       s_pixel_ready,
  output logic [7:0] lb_pixel,
  output logic       lb_pixel_valid,
  input  logic       lb_intr,
  output logic       lb_flush,
  output logic       busy,
  output logic       frame_done,
  output logic [2:0] credits,
  output logic       err
);
  localparam int PIX_W = $clog2(LINE_WIDTH);
  localparam int LN_W  = $clog2(FRAME_LINES + 1);

  line_feed_state_t  state_q;
  logic [PIX_W-1:0]  pix_q;
  logic [LN_W-1:0]   line_q, intr_cnt_q, intr_cnt_d;
  logic [7:0]        lb_pixel_q;
  logic              lb_valid_q;
  logic [CRED_W-1:0] cred_q, cred_nxt;
  logic              hs, line_end, last_line, intr_live, frame_start;

  assign s_pixel_ready = (state_q == FEED) && (cred_q != '0);
  assign hs            = s_pixel_valid && s_pixel_ready;
  assign line_end      = hs && (pix_q == PIX_W'(LINE_WIDTH - 1));
  assign last_line     = (line_q == LN_W'(FRAME_LINES - 1));
  assign intr_live     = lb_intr && (state_q inside {FEED, WAIT_CREDIT, DRAIN});
  assign frame_start   = (state_q == IDLE) && start;
  assign intr_cnt_d    = intr_cnt_q + LN_W'(intr_live);

`ifdef LINE_FEED_ERR_CHECK_EN
  logic ovf, err_q;
`endif

  lb_credit_counter #(.W(CRED_W), .MAX(NUM_LB)) u_cred (
    .clk       (clk),
    .rst       (rst),
    .load_i    (frame_start),
    .inc_i     (intr_live),
    .dec_i     (line_end),
    .cnt_o     (cred_q),
    .cnt_nxt_o (cred_nxt)
`ifdef LINE_FEED_ERR_CHECK_EN
    ,
    .ovf_o     (ovf)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pix_q      <= '0;
      line_q     <= '0;
      intr_cnt_q <= '0;
      lb_pixel_q <= '0;
      lb_valid_q <= 1'b0;
    end else begin
      lb_valid_q <= hs;
      if (hs)        lb_pixel_q <= s_pixel_data;
      if (hs)        pix_q      <= line_end ? '0 : pix_q + 1'b1;
      if (line_end)  line_q     <= line_q + 1'b1;
      if (intr_live) intr_cnt_q <= intr_cnt_d;
      case (state_q)
        IDLE: if (start) begin
          state_q    <= FEED;
          pix_q      <= '0;
          line_q     <= '0;
          intr_cnt_q <= '0;
        end
        // Decide on the post-update credit so ready drops on the very next cycle.
        FEED: if (line_end) begin
          if (last_line)            state_q <= DRAIN;
          else if (cred_nxt == '0)  state_q <= WAIT_CREDIT;
        end
        WAIT_CREDIT: if (cred_q != '0) state_q <= FEED;
        // A 3x3 window yields FRAME_LINES-2 output rows, one interrupt each.
        DRAIN: if (intr_cnt_d >= LN_W'(FRAME_LINES - 2)) state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lb_pixel       = lb_pixel_q;
  assign lb_pixel_valid = lb_valid_q;
  assign busy           = (state_q != IDLE);
  assign frame_done     = (state_q == DONE);
  assign lb_flush       = (state_q == DONE);
  assign credits        = cred_q;

`ifdef LINE_FEED_ERR_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (ovf || (lb_intr && (state_q == IDLE)) || (start && (state_q != IDLE)))
      err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_line_feed_scheduler.sv
// Randomized scoreboard bench for line_feed_scheduler (16-pixel lines, 8-line frames).
module tb_line_feed_scheduler;
  localparam int LW = 16;
  localparam int FL = 8;
  localparam int NB = 4;
`ifdef LINE_FEED_ERR_CHECK_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, s_pixel_valid, s_pixel_ready, lb_pixel_valid;
  logic       lb_intr, lb_flush, busy, frame_done, err;
  logic [7:0] s_pixel_data, lb_pixel;
  logic [2:0] credits;

  line_feed_scheduler #(.LINE_WIDTH(LW), .FRAME_LINES(FL), .NUM_LB(NB)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_pixel_data(s_pixel_data), .s_pixel_valid(s_pixel_valid), .s_pixel_ready(s_pixel_ready),
    .lb_pixel(lb_pixel), .lb_pixel_valid(lb_pixel_valid), .lb_intr(lb_intr),
    .lb_flush(lb_flush), .busy(busy), .frame_done(frame_done), .credits(credits), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [7:0] d; } exp_t;
  exp_t exp_q[$];

  int n_chk = 0, n_pass = 0;

  // Reference model: credits = pool - lines written + rows read, clamped to [0, NB].
  int m_cred = NB, frame_hs = 0, hs_total = 0, m_intr = 0, done_due = -1, fd_seen = 0;
  bit in_frame = 0, chk_ready_next = 0, exp_ready_next = 0, chk_idle_next = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic fail(input string nm);
    n_chk++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  task automatic tick(input bit vld, input bit intr, input bit st, input bit intr_on_last = 0);
    logic [7:0] d;
    bit hs, ld, ir;
    @(negedge clk);
    chk("credits", credits, m_cred);
    if (chk_ready_next) begin chk("ready_after_hs", s_pixel_ready, exp_ready_next); chk_ready_next = 0; end
    if (chk_idle_next)  begin chk("busy_after_done", busy, 0); chk_idle_next = 0; end
    if (frame_done) begin
      chk("frame_done_cycle", cyc, done_due);
      chk("lb_flush_with_done", lb_flush, 1);
      chk("frame_pixels", frame_hs, LW * FL);
      fd_seen++; in_frame = 0; chk_idle_next = 1; done_due = -1;
    end else begin
      chk("lb_flush_quiet", lb_flush, 0);
      if (done_due >= 0 && cyc > done_due) begin fail("frame_done_missing"); done_due = -1; end
    end

    d  = 8'($urandom);
    ir = intr;
    if (intr_on_last && vld && s_pixel_ready && (frame_hs % LW == LW - 1)) ir = 1;
    s_pixel_valid = vld; s_pixel_data = d; lb_intr = ir; start = st;
    hs = vld && s_pixel_ready;
    if (hs) begin exp_q.push_back('{cyc + 1, d}); hs_total++; end

    if (st && !busy && !rst) begin
      in_frame = 1; m_cred = NB; frame_hs = 0; m_intr = 0;
    end else if (in_frame) begin
      ld = hs && (frame_hs % LW == LW - 1);
      if (hs) frame_hs++;
      m_cred = m_cred - int'(ld) + int'(ir);
      if (m_cred > NB) m_cred = NB;
      if (m_cred < 0)  m_cred = 0;
      if (ir) begin
        m_intr++;
        if (m_intr == FL - 2 && frame_hs == LW * FL) done_due = cyc + 1;
      end
      if (hs) begin
        chk_ready_next = 1;
        exp_ready_next = (m_cred > 0) && (frame_hs < LW * FL);
      end
    end
  endtask

  // Output monitor: every lb_pixel_valid must match the oldest accepted pixel, one cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (lb_pixel_valid) begin
      if (exp_q.size() == 0) fail("unexpected_pixel");
      else begin
        e = exp_q.pop_front();
        chk("pixel_latency", cyc, e.due);
        chk("pixel_data", lb_pixel, e.d);
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      fail("missing_pixel");
      void'(exp_q.pop_front());
    end
  end

  initial begin
    int wc_issued, lines_done, rows;
    bit ir;
    rst = 1; start = 0; s_pixel_valid = 0; s_pixel_data = 0; lb_intr = 0;
    repeat (3) tick(0, 0, 0);
    chk("rst_ready", s_pixel_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_credits", credits, NB);
    chk("rst_valid", lb_pixel_valid, 0);
    chk("rst_pixel", lb_pixel, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err", err, 0);
    rst = 0;

    // Frame 1: no interrupts -> exactly NB lines then stall.
    tick(0, 0, 1);
    repeat (100) tick(1, 0, 0);
    chk("stall_hs_count", hs_total, NB * LW);
    chk("stall_ready", s_pixel_ready, 0);
    chk("stall_busy", busy, 1);

    // One credit back -> exactly one more line.
    tick(1, 1, 0);
    repeat (40) tick(1, 0, 0);
    chk("one_credit_hs_count", hs_total, NB * LW + LW);

    // Two credits, then an interrupt coinciding with the end of line 6.
    tick(0, 1, 0);
    tick(0, 0, 0);
    tick(0, 1, 0);
    for (int i = 0; i < 200 && frame_hs < FL * LW; i++) tick(1, 0, 0, frame_hs < 6 * LW);
    chk("frame1_pixels", hs_total, FL * LW);

    // Drain: two more row interrupts complete the frame.
    for (int i = 0; i < 20; i++) tick(1, (i == 3) || (i == 8), 0);
    chk("frame1_done_count", fd_seen, 1);
    chk("drain_no_pixels", hs_total, FL * LW);
    chk("frame1_idle", busy, 0);
    chk("err_frame1", err, 0);

    // Stray interrupt while idle.
    tick(0, 1, 0);
    tick(0, 0, 0);
    chk("err_idle_intr", err, ERR_EXP);

    // Frame 2: random source valid, window-controller model returning one row per line past two.
    wc_issued = 0;
    tick(0, 0, 1);
    for (int i = 0; i < 3000 && fd_seen < 2; i++) begin
      lines_done = frame_hs / LW;
      rows = (lines_done >= 3) ? lines_done - 2 : 0;
      ir = in_frame && (rows > wc_issued) && ($urandom_range(0, 2) == 0);
      if (ir) wc_issued++;
      tick($urandom_range(0, 3) != 0, ir, i == 50);
    end
    if (fd_seen != 2) fail("frame2_timeout");
    chk("frame2_intrs", wc_issued, FL - 2);
    chk("total_pixels", hs_total, 2 * FL * LW);
    repeat (4) tick(0, 0, 0);
    chk("end_busy", busy, 0);
    chk("err_sticky", err, ERR_EXP);
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
